pcs_tx_gearbox: RTL and testbench
=================================

# pcs_tx_gearbox

Parametrised transmit gearbox for the 10G PCS. It accepts 66-bit encoded blocks (2-bit sync header plus 64-bit payload) from the 64b/66b encoder through a valid/ready handshake. It emits a continuous DATA_WIDTH-bit stream toward the PMA serializer. Compared with the fixed 32-bit gearbox it adds three things: selectable output width, backpressure instead of a fixed pause schedule, and flush, underrun and sync-header-error reporting.

## Interface
- DATA_WIDTH, 32, output word width; legal values 16, 32, 64.
- HDR_WIDTH, 2, sync header width; fixed at 2.
- BUF_BITS, 66+2*DATA_WIDTH, derived (localparam), bit buffer capacity.

Ports:
- i_clk  in  1  single clock for all logic.
- i_reset  in  1  reset; synchronous and active-high.
- i_flush  in  1  synchronous flush of buffered bits.
- i_hdr  in  2  sync header of the offered block.
- i_data  in  64  payload of the offered block.
- i_valid  in  1  block offered.
- o_ready  out  1  gearbox can take a block this cycle (combinational from registers and i_flush).
- o_data  out  DATA_WIDTH  output word; bit 0 is transmitted first.
- o_valid  out  1  o_data carries line bits.
- o_underrun  out  1  one-cycle pulse: stream was running and no full word was available.
- o_hdr_err  out  1  one-cycle pulse: an accepted block had header 2'b00 or 2'b11.

## Operation
- Serial order of a block: hdr[0], hdr[1], data[0] … data[63]. Bits are packed LSB-first into a BUF_BITS shift buffer, and cnt holds the number of valid bits.
- Accept: i_valid && o_ready at a rising edge.
- o_ready = !i_flush && (cnt' + 66 <= BUF_BITS), where cnt' = cnt − DATA_WIDTH if cnt >= DATA_WIDTH, else cnt' = cnt.
- Each edge, when not in reset or flush, proceeds in this order:
  - Output: if cnt >= DATA_WIDTH, then o_data <= buf[DATA_WIDTH-1:0], o_valid <= 1, buffer shifts down DATA_WIDTH. Otherwise o_valid <= 0 and o_data holds its value.
  - Append: if accepted, {i_data, i_hdr} is written at bit position cnt', and cnt <= cnt' + 66.
- running flag:
  - Set on the first edge that drives o_valid = 1.
  - Cleared by reset or flush.
  - o_underrun <= running && (cnt < DATA_WIDTH) at that edge.
- o_hdr_err <= 1 on the edge accepting a block with i_hdr in {00, 11}. The block is still passed through unaltered; header correction is not this block's job.
- Flush (i_flush = 1 at an edge):
  - cnt <= 0, running <= 0, o_valid <= 0, o_underrun <= 0.
  - o_ready is low, so no block is accepted in that cycle.
  - o_data holds its value.
- States (implicit in running): IDLE (running = 0) → STREAM on the first output; STREAM → IDLE only on flush or reset. Underrun does not leave STREAM.
- Width rules:
  - cnt is $clog2(BUF_BITS+1) bits and never exceeds BUF_BITS.
  - Buffer bits at or above cnt are don't-care but must never reach o_data.
- Throughput: a continuous output requires an average of DATA_WIDTH/66 accepts per cycle. With DATA_WIDTH = 32 that is 16 accepts per 33 cycles.

## Timing
- Reset values: o_data = 0, o_valid = 0, o_underrun = 0, o_hdr_err = 0, cnt = 0, running = 0. o_ready reads 1 in the first cycle after reset deassertion.
- Latency: a block accepted into an empty buffer at edge k produces its first word on o_data/o_valid after edge k+1.
- o_hdr_err and o_underrun are registered and valid for exactly one cycle after the causing edge.
- Reset mid-stream: all buffered bits are discarded at that edge, with no partial word output.
- Flush and reset asserted together: reset wins, with identical effect.
- i_valid may stay high while o_ready is low. The block is held upstream, and i_hdr/i_data must remain stable until accepted.

## Test plan
- Single block, DATA_WIDTH=32, i_hdr=2'b01, i_data=64'h0123_4567_89AB_CDEF, accepted at edge 1:
  - edge 2 → o_data=32'h26AF_37BD, o_valid=1.
  - edge 3 → o_data=32'h048D_159E.
  - edge 4 → o_valid=0, o_underrun=1 (2 residual bits).
- Continuous random blocks with i_valid held high, DATA_WIDTH=32:
  - After the first output, o_valid stays 1 and o_underrun never pulses.
  - Every 66-cycle window has exactly 32 accepts.
  - The bit stream matches a bit-queue reference model.
- Width sweep: repeat the continuous test at DATA_WIDTH=16 and 64. Required accept counts per window are 8 per 33 cycles and 32 per 33 cycles respectively, with no underrun.
- Header error: accept i_hdr=2'b11 then i_hdr=2'b00 → o_hdr_err pulses after each accepting edge, and the header bits appear unaltered on the line.
- Flush mid-stream, with cnt=50 and i_valid=1:
  - Flush edge: no accept and o_ready=0 in that cycle.
  - Next edge: o_valid=0 and o_underrun=0.
  - Next accept restarts with first-word latency of 1 cycle.
- Backpressure: hold i_valid=1 and verify o_ready=0 whenever cnt'+66 > BUF_BITS. Verify no block is lost or duplicated across 1000 random valid patterns, checked against the reference model.

Source files
------------

// File: rtl/pcs_tx_gearbox.sv
`default_nettype none
// ============================================================================
// Module      : pcs_tx_gearbox
// Description : 66-bit block to DATA_WIDTH-bit transmit gearbox for the 10G
//               PCS. Blocks enter through a valid/ready handshake and are
//               packed LSB-first into a bit buffer. One word leaves per clock
//               whenever enough bits are buffered. Flush, underrun and
//               sync-header error reporting are included.
// Revision    : 1.0 - initial release
// ============================================================================
module pcs_tx_gearbox #(
  parameter int DATA_WIDTH = 32,
  parameter int HDR_WIDTH  = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_flush,
  input  logic [HDR_WIDTH-1:0]  i_hdr,
  input  logic [63:0]           i_data,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_underrun,
  output logic                  o_hdr_err
);

  localparam int BLK_BITS = HDR_WIDTH + 64;
  localparam int BUF_BITS = BLK_BITS + 2 * DATA_WIDTH;
  localparam int CNT_W    = $clog2(BUF_BITS + 1);

  localparam logic [CNT_W-1:0] DW_C    = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0] BLK_C   = CNT_W'(BLK_BITS);
  localparam logic [CNT_W:0]   BLK_C1  = (CNT_W + 1)'(BLK_BITS);
  localparam logic [CNT_W:0]   BUF_C1  = (CNT_W + 1)'(BUF_BITS);

  // IDLE until the first word leaves; only flush or reset return to IDLE
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t                state, state_next;
  logic [BUF_BITS-1:0]   bit_buf, buf_next;
  logic [CNT_W-1:0]      cnt, cnt_next;
  logic [CNT_W-1:0]      cnt_drain;
  logic                  word_out;
  logic                  accept;
  logic [BUF_BITS-1:0]   buf_shift;
  logic [BUF_BITS-1:0]   keep_mask;
  logic [BUF_BITS-1:0]   blk_ext;
  logic [DATA_WIDTH-1:0] data_next;
  logic                  valid_next;
  logic                  under_next;
  logic                  hdr_err_next;

  // Next-state logic: emit a word from the old buffer, then append the
  // accepted block just above whatever bits remain after the emit
  always_comb begin
    state_next   = state;
    buf_next     = bit_buf;
    cnt_next     = cnt;
    data_next    = o_data;
    valid_next   = 1'b0;
    under_next   = 1'b0;
    hdr_err_next = 1'b0;

    word_out  = (cnt >= DW_C);
    cnt_drain = word_out ? (cnt - DW_C) : cnt;
    o_ready   = !i_flush && (({1'b0, cnt_drain} + BLK_C1) <= BUF_C1);
    accept    = i_valid && o_ready;
    buf_shift = word_out ? (bit_buf >> DATA_WIDTH) : bit_buf;
    // Bits at and above the append point are stale; clear them before OR-in
    keep_mask = ~({BUF_BITS{1'b1}} << cnt_drain);
    blk_ext   = {{(BUF_BITS - BLK_BITS){1'b0}}, i_data, i_hdr} << cnt_drain;

    if (i_flush) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      if (word_out) begin
        data_next  = bit_buf[DATA_WIDTH-1:0];
        valid_next = 1'b1;
        state_next = STREAM;
      end
      under_next = (state == STREAM) && !word_out;
      buf_next   = buf_shift;
      cnt_next   = cnt_drain;
      if (accept) begin
        buf_next     = (buf_shift & keep_mask) | blk_ext;
        cnt_next     = cnt_drain + BLK_C;
        // Headers 00 and 11 are illegal; the block still goes out unchanged
        hdr_err_next = (i_hdr[0] == i_hdr[HDR_WIDTH-1]);
      end
    end
  end

  // State, buffer and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= IDLE;
      bit_buf    <= '0;
      cnt        <= '0;
      o_data     <= '0;
      o_valid    <= 1'b0;
      o_underrun <= 1'b0;
      o_hdr_err  <= 1'b0;
    end else begin
      state      <= state_next;
      bit_buf    <= buf_next;
      cnt        <= cnt_next;
      o_data     <= data_next;
      o_valid    <= valid_next;
      o_underrun <= under_next;
      o_hdr_err  <= hdr_err_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pcs_tx_gearbox.sv
`default_nettype none
// ============================================================================
// Module      : tb_pcs_tx_gearbox
// Description : Self-checking bench for pcs_tx_gearbox at widths 16/32/64.
//               Directed vector table plus reset/flush sequences and
//               streaming runs compared against a bit-queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pcs_tx_gearbox;

  logic clk;
  logic rst;
  logic flush;

  logic        valid_a [3];
  logic [1:0]  hdr_a   [3];
  logic [63:0] data_a  [3];
  logic        ready_a [3];
  logic        ovalid_a[3];
  logic        under_a [3];
  logic        herr_a  [3];
  logic [63:0] od_a    [3];

  logic [15:0] od16;
  logic [31:0] od32;
  logic [63:0] od64;

  int wid[3] = '{16, 32, 64};

  int total  = 0;
  int passed = 0;

  pcs_tx_gearbox #(.DATA_WIDTH(16)) u_dut16 (
    .i_clk(clk), .i_reset(rst), .i_flush(flush),
    .i_hdr(hdr_a[0]), .i_data(data_a[0]), .i_valid(valid_a[0]),
    .o_ready(ready_a[0]), .o_data(od16), .o_valid(ovalid_a[0]),
    .o_underrun(under_a[0]), .o_hdr_err(herr_a[0])
  );

  pcs_tx_gearbox #(.DATA_WIDTH(32)) u_dut32 (
    .i_clk(clk), .i_reset(rst), .i_flush(flush),
    .i_hdr(hdr_a[1]), .i_data(data_a[1]), .i_valid(valid_a[1]),
    .o_ready(ready_a[1]), .o_data(od32), .o_valid(ovalid_a[1]),
    .o_underrun(under_a[1]), .o_hdr_err(herr_a[1])
  );

  pcs_tx_gearbox #(.DATA_WIDTH(64)) u_dut64 (
    .i_clk(clk), .i_reset(rst), .i_flush(flush),
    .i_hdr(hdr_a[2]), .i_data(data_a[2]), .i_valid(valid_a[2]),
    .o_ready(ready_a[2]), .o_data(od64), .o_valid(ovalid_a[2]),
    .o_underrun(under_a[2]), .o_hdr_err(herr_a[2])
  );

  assign od_a[0] = {48'd0, od16};
  assign od_a[1] = {32'd0, od32};
  assign od_a[2] = od64;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        flush;
    logic        valid;
    logic [1:0]  hdr;
    logic [63:0] data;
    logic        exp_ready;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic        exp_under;
    logic        exp_herr;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs[NV];

  localparam logic [63:0] B1 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] ZZ = 64'h0;
  localparam logic [63:0] FF = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] A5 = 64'hA5A5_A5A5_A5A5_A5A5;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b1;
    flush = 1'b0;
    for (int i = 0; i < 3; i++) valid_a[i] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Streaming run on one instance against a bit-queue model
  task automatic run_stream(input int idx, input int ncyc, input bit rnd, input bit win);
    int          w;
    int          bufb;
    int          mcnt;
    int          drained;
    bit          run;
    bit          q[$];
    bit          pend;
    bit          out;
    bit          acc;
    bit          exp_rdy;
    bit          exp_under;
    logic [1:0]  h;
    logic [63:0] d;
    logic [63:0] exp_word;
    int          acc_win;
    int          win_edges;
    w         = wid[idx];
    bufb      = 66 + 2 * w;
    mcnt      = 0;
    run       = 1'b0;
    pend      = 1'b0;
    h         = 2'b00;
    d         = 64'd0;
    acc_win   = 0;
    win_edges = 0;
    do_reset();
    for (int c = 0; c < ncyc; c++) begin
      if (!pend) begin
        pend = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
        if (pend) begin
          h = 2'($urandom());
          d = {$urandom(), $urandom()};
        end
      end
      valid_a[idx] = pend;
      hdr_a[idx]   = h;
      data_a[idx]  = d;
      #1;
      drained = (mcnt >= w) ? mcnt - w : mcnt;
      exp_rdy = (drained + 66 <= bufb);
      chk($sformatf("stream%0d_ready", w), {63'd0, ready_a[idx]}, {63'd0, exp_rdy});
      out       = (mcnt >= w);
      acc       = pend && exp_rdy;
      exp_under = run && !out;
      exp_word  = 64'd0;
      if (out) for (int i = 0; i < w; i++) exp_word[i] = q.pop_front();
      if (acc) begin
        q.push_back(h[0]);
        q.push_back(h[1]);
        for (int i = 0; i < 64; i++) q.push_back(d[i]);
      end
      mcnt = drained + (acc ? 66 : 0);
      if (out) run = 1'b1;
      @(negedge clk);
      chk($sformatf("stream%0d_valid", w), {63'd0, ovalid_a[idx]}, {63'd0, out});
      chk($sformatf("stream%0d_underrun", w), {63'd0, under_a[idx]}, {63'd0, exp_under});
      chk($sformatf("stream%0d_hdr_err", w), {63'd0, herr_a[idx]},
          {63'd0, acc && (h[0] == h[1])});
      if (out) chk($sformatf("stream%0d_data", w), od_a[idx], exp_word);
      if (acc) pend = 1'b0;
      if (win && c >= 2) begin
        acc_win += acc ? 1 : 0;
        win_edges++;
        if (win_edges == 66) begin
          chk("accepts_per_66", 64'(acc_win), 64'(w));
          acc_win   = 0;
          win_edges = 0;
        end
      end
    end
    valid_a[idx] = 1'b0;
  endtask

  // Main test sequence
  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      valid_a[i] = 1'b0;
      hdr_a[i]   = 2'b00;
      data_a[i]  = 64'd0;
    end

    vecs[0]  = '{1'b0, 1'b1, 2'b01, B1, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 2'b00, ZZ, 1'b1, 1'b1, 32'h26AF_37BD, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 2'b00, ZZ, 1'b1, 1'b1, 32'h048D_159E, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 2'b00, ZZ, 1'b1, 1'b0, 32'h048D_159E, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 2'b11, ZZ, 1'b1, 1'b0, 32'h048D_159E, 1'b1, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 2'b00, FF, 1'b1, 1'b1, 32'h0000_000C, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 2'b00, ZZ, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 2'b00, ZZ, 1'b1, 1'b1, 32'hFFFF_FFC0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 2'b00, ZZ, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 2'b01, A5, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 2'b00, ZZ, 1'b1, 1'b1, 32'hA5A5_A57F, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 2'b01, B1, 1'b0, 1'b0, 32'hA5A5_A57F, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 2'b01, B1, 1'b1, 1'b0, 32'hA5A5_A57F, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 2'b00, ZZ, 1'b1, 1'b1, 32'h26AF_37BD, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 2'b00, ZZ, 1'b1, 1'b1, 32'h048D_159E, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 2'b00, ZZ, 1'b1, 1'b0, 32'h048D_159E, 1'b1, 1'b0};

    // Reset state
    do_reset();
    #1;
    chk("rst_data",     od_a[1], 64'd0);
    chk("rst_valid",    {63'd0, ovalid_a[1]}, 64'd0);
    chk("rst_underrun", {63'd0, under_a[1]},  64'd0);
    chk("rst_hdr_err",  {63'd0, herr_a[1]},   64'd0);
    chk("rst_ready",    {63'd0, ready_a[1]},  64'd1);

    // Directed table on the 32-bit instance
    for (int i = 0; i < NV; i++) begin
      flush      = vecs[i].flush;
      valid_a[1] = vecs[i].valid;
      hdr_a[1]   = vecs[i].hdr;
      data_a[1]  = vecs[i].data;
      #1;
      chk($sformatf("vec%0d_ready", i), {63'd0, ready_a[1]}, {63'd0, vecs[i].exp_ready});
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), {63'd0, ovalid_a[1]}, {63'd0, vecs[i].exp_valid});
      chk($sformatf("vec%0d_data", i), od_a[1], {32'd0, vecs[i].exp_data});
      chk($sformatf("vec%0d_underrun", i), {63'd0, under_a[1]}, {63'd0, vecs[i].exp_under});
      chk($sformatf("vec%0d_hdr_err", i), {63'd0, herr_a[1]}, {63'd0, vecs[i].exp_herr});
    end
    flush      = 1'b0;
    valid_a[1] = 1'b0;

    // Reset mid-stream discards buffered bits without a partial word
    do_reset();
    valid_a[1] = 1'b1;
    hdr_a[1]   = 2'b01;
    data_a[1]  = B1;
    @(negedge clk);
    valid_a[1] = 1'b0;
    @(negedge clk);
    chk("mid_word1", od_a[1], 64'h26AF_37BD);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", {63'd0, ovalid_a[1]}, 64'd0);
    chk("mid_rst_data",  od_a[1], 64'd0);
    rst = 1'b0;
    #1;
    chk("mid_rst_ready", {63'd0, ready_a[1]}, 64'd1);
    repeat (2) begin
      @(negedge clk);
      chk("mid_after_valid", {63'd0, ovalid_a[1]}, 64'd0);
      chk("mid_after_under", {63'd0, under_a[1]},  64'd0);
    end

    // Reset and flush together behave as reset (o_data cleared)
    valid_a[1] = 1'b1;
    hdr_a[1]   = 2'b11;
    data_a[1]  = B1;
    @(negedge clk);
    chk("rf_hdr_err", {63'd0, herr_a[1]}, 64'd1);
    valid_a[1] = 1'b0;
    @(negedge clk);
    chk("rf_word1", od_a[1], 64'h26AF_37BF);
    rst   = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    chk("rf_data",    od_a[1], 64'd0);
    chk("rf_valid",   {63'd0, ovalid_a[1]}, 64'd0);
    chk("rf_hdr_err", {63'd0, herr_a[1]},   64'd0);
    rst   = 1'b0;
    flush = 1'b0;
    #1;
    chk("rf_ready", {63'd0, ready_a[1]}, 64'd1);
    @(negedge clk);
    chk("rf_after_valid", {63'd0, ovalid_a[1]}, 64'd0);
    chk("rf_after_under", {63'd0, under_a[1]},  64'd0);

    // Continuous streaming at each width, then random-valid backpressure
    run_stream(1, 400, 1'b0, 1'b1);
    run_stream(0, 400, 1'b0, 1'b0);
    run_stream(2, 400, 1'b0, 1'b0);
    run_stream(1, 1000, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
